// File: rtl/sbp_pkg.sv
// Shared types and constants for the SBP lookup pipeline node memories.
// Holds the node word layout and the stage-memory FSM state encoding.
package sbp_pkg;

   localparam int SBP_STAGE_ID_BITS = 6;
   localparam int SBP_LOCATION_BITS = 11;
   localparam int SBP_NODE_BITS     = 64;

   // One trie node as stored in a stage memory; an all-zero word has
   // child_stage_id 0, which terminates a lookup.
   typedef struct packed {
      logic [31:0]                  prefix;
      logic [1:0]                   pad0;
      logic [5:0]                   prefix_length;
      logic [1:0]                   pad1;
      logic [SBP_STAGE_ID_BITS-1:0] child_stage_id;
      logic [0:0]                   pad2;
      logic [SBP_LOCATION_BITS-1:0] child_location;
      logic [1:0]                   pad3;
      logic                         has_left;
      logic                         has_right;
   } sbp_node_t;

   localparam sbp_node_t SBP_NODE_ZERO = '0;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } sbp_mem_state_e;

endpackage

// File: rtl/sbp_sdp_ram.sv
// Inferable simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address on one edge return the old contents.
module sbp_sdp_ram #(
   parameter int ADDR_BITS = 11,
   parameter int DATA_BITS = 64
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  logic [DATA_BITS-1:0] wdata_i,
   input  logic [ADDR_BITS-1:0] raddr_i,
   output logic [DATA_BITS-1:0] rdata_o
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [DATA_BITS-1:0] rdata_q;

   // Write port and registered read port; no reset so the array maps to block RAM.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sbp_stage_mem.sv
// Per-stage node memory feeding one sbp_lookup_stage.
// After reset it zero-fills every entry, then accepts control-plane updates.
// Optional macro SBP_STAGE_MEM_BYPASS_EN: forward a same-edge write to the
// read port (write-first); otherwise the read port is read-first.
module sbp_stage_mem
   import sbp_pkg::*;
#(
   parameter int ADDR_BITS = 11,
   parameter int DATA_BITS = SBP_NODE_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] addr,
   output logic [DATA_BITS-1:0] data,
   input  logic                 upd_valid,
   output logic                 upd_ready,
   input  logic [ADDR_BITS-1:0] upd_addr,
   input  logic [DATA_BITS-1:0] upd_data,
   output logic                 init_done
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

   sbp_mem_state_e       state_q, state_d;
   logic [ADDR_BITS-1:0] cnt_q, cnt_d;
   logic                 run_q, run_d;
   logic                 force_zero_q, force_zero_d;

   logic                 ram_we;
   logic [ADDR_BITS-1:0] ram_waddr;
   logic [DATA_BITS-1:0] ram_wdata;
   logic [DATA_BITS-1:0] ram_rdata;
   logic                 upd_fire;

   // Next-state logic: INIT sweeps zeros over every address once, RUN passes updates.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ram_we    = 1'b0;
      ram_waddr = upd_addr;
      ram_wdata = upd_data;
      upd_fire  = 1'b0;
      case (state_q)
         ST_INIT: begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = '0;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            upd_fire = upd_valid && run_q;
            ram_we   = upd_fire;
         end
         default: state_d = ST_INIT;
      endcase
      run_d        = (state_d == ST_RUN);
      // Any read sampled while still sweeping returns a terminating zero word.
      force_zero_d = (state_q == ST_INIT);
   end

   // State, sweep counter and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         cnt_q        <= '0;
         run_q        <= 1'b0;
         force_zero_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         run_q        <= run_d;
         force_zero_q <= force_zero_d;
      end
   end

   sbp_sdp_ram #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (addr),
      .rdata_o (ram_rdata)
   );

`ifdef SBP_STAGE_MEM_BYPASS_EN
   logic                 byp_hit_q;
   logic [DATA_BITS-1:0] byp_data_q;

   // Capture a write landing on the address being read so it is returned immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         byp_hit_q  <= 1'b0;
         byp_data_q <= '0;
      end else begin
         byp_hit_q  <= upd_fire && (upd_addr == addr);
         byp_data_q <= upd_data;
      end
   end

   assign data = force_zero_q ? DATA_BITS'(SBP_NODE_ZERO) :
                 (byp_hit_q ? byp_data_q : ram_rdata);
`else
   assign data = force_zero_q ? DATA_BITS'(SBP_NODE_ZERO) : ram_rdata;
`endif

   assign upd_ready = run_q;
   assign init_done = run_q;

endmodule
